// File: rtl/imem_loader.sv
// Streams a length-prefixed little-endian program image into instruction memory,
// holding the core in reset until every declared word has been consumed.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  ByteIn,
    input  logic        ByteValid,
    output logic        ByteReady,
    input  logic        Start,
    output logic        InstrWrite,
    output logic [31:0] WriteInst,
    output logic [31:0] WriteAdress,
    output logic        CoreReset,
    output logic        LoadDone,
    output logic        OverflowErr
);

    typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_WRITE, S_DONE} state_t;

    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

    state_t      state_q;
    logic [15:0] count_q;
    logic [15:0] word_idx_q;
    logic [1:0]  byte_idx_q;
    logic [23:0] word_q;
    logic        ready_q, iwr_q, core_rst_q, done_q, ovf_q;
    logic [31:0] winst_q, waddr_q;

    logic        xfer;
    logic [15:0] count_d;
    logic [16:0] word_idx_d;
    logic [31:0] waddr_d;

    assign xfer       = ByteValid & ready_q;
    assign count_d    = {ByteIn, count_q[7:0]};
    assign word_idx_d = {1'b0, word_idx_q} + 17'd1;
    assign waddr_d    = BASE_ADDR + {14'd0, word_idx_q, 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_LEN0;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            ready_q    <= 1'b1;
            iwr_q      <= 1'b0;
            winst_q    <= '0;
            waddr_q    <= BASE_ADDR;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            iwr_q <= 1'b0;
            unique case (state_q)
                S_LEN0: if (xfer) begin
                    count_q[7:0] <= ByteIn;
                    state_q      <= S_LEN1;
                end
                S_LEN1: if (xfer) begin
                    count_q[15:8] <= ByteIn;
                    ovf_q         <= ovf_q | ({16'd0, count_d} > MAX_W);
                    if (count_d == 16'd0) begin
                        state_q    <= S_DONE;
                        ready_q    <= 1'b0;
                        core_rst_q <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: if (xfer) begin
                    byte_idx_q <= byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: word_q[7:0]   <= ByteIn;
                        2'd1: word_q[15:8]  <= ByteIn;
                        2'd2: word_q[23:16] <= ByteIn;
                        default: begin
                            // Last byte goes straight into the write register.
                            state_q <= S_WRITE;
                            ready_q <= 1'b0;
                            iwr_q   <= ({16'd0, word_idx_q} < MAX_W);
                            winst_q <= {ByteIn, word_q};
                            waddr_q <= waddr_d;
                        end
                    endcase
                end
                S_WRITE: begin
                    word_idx_q <= word_idx_d[15:0];
                    if (word_idx_d == {1'b0, count_q}) begin
                        state_q    <= S_DONE;
                        core_rst_q <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        state_q <= S_DATA;
                        ready_q <= 1'b1;
                    end
                end
                S_DONE: if (Start) begin
                    state_q    <= S_LEN0;
                    ready_q    <= 1'b1;
                    core_rst_q <= 1'b1;
                    done_q     <= 1'b0;
                    ovf_q      <= 1'b0;
                    word_idx_q <= '0;
                    byte_idx_q <= '0;
                end
                default: state_q <= S_LEN0;
            endcase
        end
    end

    assign ByteReady   = ready_q;
    assign InstrWrite  = iwr_q;
    assign WriteInst   = winst_q;
    assign WriteAdress = waddr_q;
    assign CoreReset   = core_rst_q;
    assign LoadDone    = done_q;
    assign OverflowErr = ovf_q;

endmodule
